// File: rtl/aes_block_stream.sv
// aes_block_stream: packs four 32-bit words into a block, runs the AES core once,
// and streams the 128-bit result back out as four 32-bit words.
module aes_block_stream #(
    parameter int TIMEOUT_CYC = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         cfg_enc_dec,
    input  logic [1:0]   cfg_mode,
    output logic         core_start,
    output logic         core_enc_dec,
    output logic [1:0]   core_mode,
    output logic [127:0] core_data_in,
    input  logic         core_done,
    input  logic [127:0] core_data_out,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         busy,
    output logic         err_timeout
);
    typedef enum logic [1:0] {FILL, KICK, WAIT, DRAIN} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);
    state_t          state;
    logic [1:0]      cnt, idx;
    logic [7:0]      timer;
    logic [3:0][31:0] block, out_buf;
    assign core_data_in = block;
    assign m_data = out_buf[~idx];
    assign busy = (state != FILL) || (cnt != 2'd0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FILL;
            cnt          <= '0;
            idx          <= '0;
            timer        <= '0;
            block        <= '0;
            out_buf      <= '0;
            s_ready      <= 1'b0;
            core_start   <= 1'b0;
            core_enc_dec <= 1'b0;
            core_mode    <= '0;
            m_valid      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            core_start  <= 1'b0;
            err_timeout <= 1'b0;
            // timer runs through KICK too, so the abort lands TIMEOUT_CYC cycles after core_start
            if (timer != 8'hff) timer <= timer + 8'd1;
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        block[~cnt] <= s_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd0) begin
                            core_enc_dec <= cfg_enc_dec;
                            core_mode    <= cfg_mode;
                        end
                        if (cnt == 2'd3) begin
                            state      <= KICK;
                            s_ready    <= 1'b0;
                            core_start <= 1'b1;
                            timer      <= '0;
                        end
                    end
                end
                KICK: state <= WAIT;
                WAIT: begin
                    if (core_done) begin
                        out_buf <= core_data_out;
                        idx     <= '0;
                        m_valid <= 1'b1;
                        state   <= DRAIN;
                    end else if (timer >= LAST) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        s_ready     <= 1'b1;
                        state       <= FILL;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            m_valid <= 1'b0;
                            cnt     <= '0;
                            s_ready <= 1'b1;
                            state   <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_block_stream.sv
// tb_aes_block_stream: directed checks of the word-stream wrapper around a stub AES core
// that answers a fixed number of cycles after core_start.
module tb_aes_block_stream;
    logic         clk = 1'b0, reset = 1'b0, s_valid = 1'b0, cfg_enc_dec = 1'b0, m_ready = 1'b0;
    logic         done_m = 1'b0, done_s = 1'b0;
    logic [1:0]   cfg_mode = 2'b00;
    logic [31:0]  s_data = '0;
    logic [127:0] res = '0;
    logic         s_ready, core_start, core_enc_dec, m_valid, busy, err_timeout, core_done;
    logic [1:0]   core_mode;
    logic [127:0] core_data_in;
    logic [31:0]  m_data;
    int passes = 0, total = 0, cyc = 0, starts = 0, errs = 0, mv_cnt = 0, exp_starts = 0;
    int core_dly = 11, ctr = 0;
    bit core_en = 1'b1, act = 1'b0;
    localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    assign core_done = done_m | done_s;

    aes_block_stream #(.TIMEOUT_CYC(32)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_enc_dec(cfg_enc_dec), .cfg_mode(cfg_mode), .core_start(core_start),
        .core_enc_dec(core_enc_dec), .core_mode(core_mode), .core_data_in(core_data_in),
        .core_done(core_done), .core_data_out(res), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // stub core: done pulses core_dly cycles after the start pulse
    always @(negedge clk) begin
        if (core_start) starts++;
        if (err_timeout) errs++;
        if (m_valid) mv_cnt++;
        done_m = 1'b0;
        if (!reset) act = 1'b0;
        else if (core_start && core_en) begin
            act = 1'b1;
            ctr = core_dly;
        end else if (act) begin
            ctr--;
            if (ctr == 0) begin
                done_m = 1'b1;
                act = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_word(input logic [31:0] d, input bit gap, input bit keep);
        int n = 0;
        if (gap) begin
            s_valid = 1'b0;
            tick();
        end
        s_data = d;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) chk("s_ready_wait", 128'(s_ready), 128'd1);
        tick();
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input bit gap, input bit keep);
        for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], gap, keep);
        exp_starts++;
        chk("kick_start", 128'(core_start), 128'd1);
        chk("kick_data_in", core_data_in, blk);
        chk("kick_s_ready", 128'(s_ready), 128'd0);
    endtask

    task automatic recv(input logic [31:0] exp, input int stall, input string tag);
        int n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 128'(m_data), 128'(exp));
        chk("drain_s_ready", 128'(s_ready), 128'd0);
        for (int k = 0; k < stall; k++) begin
            m_ready = 1'b0;
            tick();
            chk("stall_m_data", 128'(m_data), 128'(exp));
            chk("stall_m_valid", 128'(m_valid), 128'd1);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic recv_block(input logic [127:0] blk, input int stall);
        for (int i = 0; i < 4; i++) recv(blk[127-32*i -: 32], stall, "m_data_word");
        chk("after_m_valid", 128'(m_valid), 128'd0);
        chk("after_s_ready", 128'(s_ready), 128'd1);
        chk("after_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        int s, n, mv, e;
        tick();
        tick();
        chk("rst_s_ready", 128'(s_ready), 128'd0);
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_core_start", 128'(core_start), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err", 128'(err_timeout), 128'd0);
        chk("rst_data_in", core_data_in, 128'd0);
        reset = 1'b1;
        tick();
        chk("rel_s_ready", 128'(s_ready), 128'd1);

        // FIPS-197 C.1 vector through the stub core
        res = C1_OUT;
        send_block(C1_IN, 1'b0, 1'b0);
        s = cyc;
        chk("c1_enc_dec", 128'(core_enc_dec), 128'd0);
        chk("c1_mode", 128'(core_mode), 128'd0);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        chk("start_to_mvalid", 128'(cyc - s), 128'd12);
        recv_block(C1_OUT, 0);
        chk("c1_starts", 128'(starts), 128'(exp_starts));

        // backpressure on both sides
        res = 128'hdeadbeef_01234567_89abcdef_fedcba98;
        send_block(128'hcafef00d_11112222_33334444_55556666, 1'b1, 1'b0);
        recv_block(128'hdeadbeef_01234567_89abcdef_fedcba98, 3);
        chk("bp_starts", 128'(starts), 128'(exp_starts));

        // timeout: core never answers
        core_en = 1'b0;
        mv = mv_cnt;
        e = errs;
        send_block(128'h0a0b0c0d_1a1b1c1d_2a2b2c2d_3a3b3c3d, 1'b0, 1'b0);
        s = cyc;
        n = 0;
        while (!err_timeout && n < 60) begin
            tick();
            n++;
        end
        chk("to_cycle", 128'(cyc - s), 128'd32);
        chk("to_pulse", 128'(err_timeout), 128'd1);
        chk("to_s_ready", 128'(s_ready), 128'd1);
        chk("to_busy", 128'(busy), 128'd0);
        tick();
        chk("to_pulse_end", 128'(err_timeout), 128'd0);
        chk("to_err_count", 128'(errs - e), 128'd1);
        chk("to_no_mvalid", 128'(mv_cnt), 128'(mv));
        core_en = 1'b1;
        res = 128'h11223344_55667788_99aabbcc_ddeeff00;
        send_block(128'h01010101_02020202_03030303_04040404, 1'b0, 1'b0);
        recv_block(128'h11223344_55667788_99aabbcc_ddeeff00, 0);

        // reset while waiting for the core
        send_block(C1_IN, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rw_s_ready", 128'(s_ready), 128'd0);
        chk("rw_busy", 128'(busy), 128'd0);
        chk("rw_core_start", 128'(core_start), 128'd0);
        chk("rw_data_in", core_data_in, 128'd0);
        tick();
        reset = 1'b1;
        mv = mv_cnt;
        tick();
        chk("rw_rel_s_ready", 128'(s_ready), 128'd1);
        for (int k = 0; k < 15; k++) tick();
        chk("rw_no_mvalid", 128'(mv_cnt), 128'(mv));
        chk("rw_starts", 128'(starts), 128'(exp_starts));

        // reset mid-drain after two words
        res = C1_OUT;
        send_block(C1_IN, 1'b0, 1'b0);
        recv(C1_OUT[127:96], 0, "rd_w0");
        recv(C1_OUT[95:64], 0, "rd_w1");
        reset = 1'b0;
        #1;
        chk("rd_m_valid", 128'(m_valid), 128'd0);
        chk("rd_busy", 128'(busy), 128'd0);
        tick();
        reset = 1'b1;
        mv = mv_cnt;
        tick();
        chk("rd_rel_s_ready", 128'(s_ready), 128'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("rd_no_mvalid", 128'(mv_cnt), 128'(mv));
        chk("rd_starts", 128'(starts), 128'(exp_starts));

        // config sampled only with word 0
        res = C1_OUT;
        cfg_enc_dec = 1'b1;
        cfg_mode = 2'b10;
        send_word(C1_IN[127:96], 1'b0, 1'b0);
        cfg_enc_dec = 1'b0;
        cfg_mode = 2'b00;
        send_word(C1_IN[95:64], 1'b0, 1'b0);
        send_word(C1_IN[63:32], 1'b0, 1'b0);
        send_word(C1_IN[31:0], 1'b0, 1'b0);
        exp_starts++;
        chk("cfg_enc_dec_kick", 128'(core_enc_dec), 128'd1);
        chk("cfg_mode_kick", 128'(core_mode), 128'd2);
        for (int k = 0; k < 6; k++) tick();
        chk("cfg_enc_dec_wait", 128'(core_enc_dec), 128'd1);
        chk("cfg_mode_wait", 128'(core_mode), 128'd2);
        recv_block(C1_OUT, 0);

        // spurious done in FILL, then three back-to-back blocks with s_valid held
        res = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
        done_s = 1'b1;
        tick();
        tick();
        done_s = 1'b0;
        chk("spur_m_valid", 128'(m_valid), 128'd0);
        chk("spur_busy", 128'(busy), 128'd0);
        for (int b = 0; b < 3; b++) begin
            res = {4{32'(b + 32'ha5a50000)}};
            send_block({32'(b * 4), 32'(b * 4 + 1), 32'(b * 4 + 2), 32'(b * 4 + 3)}, 1'b0, 1'b1);
            recv_block({4{32'(b + 32'ha5a50000)}}, 0);
        end
        s_valid = 1'b0;
        chk("b2b_starts", 128'(starts), 128'(exp_starts));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
